// File: rtl/sdu_chn_pkt_fifo_pkg.sv
// Shared constants and write-FSM encoding for the per-channel SDU packet FIFO.
package sdu_chn_pkt_fifo_pkg;

  localparam int unsigned SOP_BIT = 17;
  localparam int unsigned EOP_BIT = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDrop  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sdu_chn_pkt_fifo_if.sv
// Channel-receiver write bus and scheduler read bus of one packet FIFO instance.
interface sdu_chn_pkt_fifo_if #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  wr_dval;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  sdu_chn_rden;
  logic                  chn_sdu_dval;
  logic [DATA_WIDTH-1:0] chn_sdu_data;
  logic                  chn_sdu_empty;
  logic [ADDR_WIDTH:0]   pkt_cnt;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  modport master (
    output wr_dval, wr_data, sdu_chn_rden,
    input  chn_sdu_dval, chn_sdu_data, chn_sdu_empty, pkt_cnt, drop_cnt
  );

  modport slave (
    input  wr_dval, wr_data, sdu_chn_rden,
    output chn_sdu_dval, chn_sdu_data, chn_sdu_empty, pkt_cnt, drop_cnt
  );
endinterface

// File: rtl/sdu_chn_pkt_fifo_dpram.sv
// Simple dual-port RAM: registered write, synchronous read with one cycle of latency.
module sdu_chn_pkt_fifo_dpram #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sdu_chn_pkt_fifo.sv
// Store-and-forward packet FIFO: only whole packets become visible to the scheduler;
// malformed or overflowing packets are rolled back to the last commit point and counted.
module sdu_chn_pkt_fifo
  import sdu_chn_pkt_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_sys,
  sdu_chn_pkt_fifo_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   pcnt_t;
  typedef logic [CNT_WIDTH-1:0]  dcnt_t;

  wr_state_e  r_state;
  ptr_t       r_wptr;
  ptr_t       r_commit_ptr;
  ptr_t       r_rptr;
  pcnt_t      r_pkt_cnt;
  dcnt_t      r_drop_cnt;
  logic       r_empty;
  logic       r_dval;
  logic [Depth-1:0] r_eop_map;

  logic                  w_sop;
  logic                  w_eop;
  logic                  w_store;
  logic                  w_restart;
  logic                  w_full;
  logic                  w_ram_we;
  logic                  w_commit;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_eop_pop;
  ptr_t                  w_waddr;
  ptr_t                  w_waddr_inc;
  pcnt_t                 w_pkt_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_sop = bus.wr_data[SOP_BIT];
  assign w_eop = bus.wr_data[EOP_BIT];

  // A sop inside WRITE abandons the partial packet and restarts at the commit point.
  assign w_store     = bus.wr_dval && ((r_state == StWrite) || w_sop);
  assign w_restart   = bus.wr_dval && (r_state == StWrite) && w_sop;
  assign w_waddr     = w_restart ? r_commit_ptr : r_wptr;
  assign w_waddr_inc = w_waddr + ptr_t'(1);
  assign w_full      = (w_waddr_inc == r_rptr);
  assign w_ram_we    = w_store && !w_full;
  assign w_commit    = w_ram_we && w_eop;
  assign w_drop      = (w_store && w_full) || w_restart;

  // pkt_cnt != 0 guarantees rptr lies inside a committed packet.
  assign w_pop     = bus.sdu_chn_rden && (r_pkt_cnt != '0);
  assign w_eop_pop = w_pop && r_eop_map[r_rptr];

  always_comb begin
    w_pkt_cnt_nxt = r_pkt_cnt;
    if (w_commit && !w_eop_pop) begin
      w_pkt_cnt_nxt = r_pkt_cnt + pcnt_t'(1);
    end else if (!w_commit && w_eop_pop) begin
      w_pkt_cnt_nxt = r_pkt_cnt - pcnt_t'(1);
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_sys) begin
      r_state      <= StIdle;
      r_wptr       <= '0;
      r_commit_ptr <= '0;
      r_rptr       <= '0;
      r_pkt_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_empty      <= 1'b1;
      r_dval       <= 1'b0;
    end else begin
      r_pkt_cnt <= w_pkt_cnt_nxt;
      r_empty   <= (w_pkt_cnt_nxt == '0);
      r_dval    <= w_pop;
      if (w_pop) begin
        r_rptr <= r_rptr + ptr_t'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + dcnt_t'(1);
      end
      if (w_store && w_full) begin
        r_wptr  <= r_commit_ptr;
        r_state <= w_eop ? StIdle : StDrop;
      end else if (w_ram_we) begin
        r_wptr <= w_waddr_inc;
        if (w_eop) begin
          r_commit_ptr <= w_waddr_inc;
          r_state      <= StIdle;
        end else begin
          r_state <= StWrite;
        end
      end else if (bus.wr_dval && (r_state == StDrop) && w_eop) begin
        r_state <= StIdle;
      end
    end
  end

  // Per-word eop flags let an eop pop decrement pkt_cnt in the cycle it is accepted.
  always_ff @(posedge i_clk_sys) begin
    if (w_ram_we) begin
      r_eop_map[w_waddr] <= w_eop;
    end
  end

  sdu_chn_pkt_fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dpram (
    .i_clk   (i_clk_sys),
    .i_we    (w_ram_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.wr_data),
    .i_re    (w_pop),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  assign bus.chn_sdu_dval  = r_dval;
  assign bus.chn_sdu_data  = r_dval ? w_ram_rdata : '0;
  assign bus.chn_sdu_empty = r_empty;
  assign bus.pkt_cnt       = r_pkt_cnt;
  assign bus.drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_sdu_chn_pkt_fifo.sv
// Directed bench for sdu_chn_pkt_fifo with a 16-word RAM so overflow and pointer wrap are reachable.
module tb_sdu_chn_pkt_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sdu_chn_pkt_fifo_if #(.DATA_WIDTH(18), .ADDR_WIDTH(4), .CNT_WIDTH(16)) bus ();

  sdu_chn_pkt_fifo #(.DATA_WIDTH(18), .ADDR_WIDTH(4), .CNT_WIDTH(16)) dut (
    .i_clk_sys (clk),
    .i_rst_sys (rst),
    .bus       (bus)
  );

  task automatic step(input logic wv, input logic [17:0] wd, input logic rd);
    bus.wr_dval      = wv;
    bus.wr_data      = wd;
    bus.sdu_chn_rden = rd;
    @(posedge clk);
    #1;
    bus.wr_dval      = 1'b0;
    bus.wr_data      = '0;
    bus.sdu_chn_rden = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop one word and check it appears the following cycle.
  task automatic pop_chk(input string tag, input logic [17:0] exp);
    step(1'b0, 18'h0, 1'b1);
    chk({tag, "_dval"}, 32'(bus.chn_sdu_dval), 32'd1);
    chk({tag, "_data"}, 32'(bus.chn_sdu_data), 32'(exp));
  endtask

  initial begin
    logic [17:0] d;
    bus.wr_dval      = 1'b0;
    bus.wr_data      = '0;
    bus.sdu_chn_rden = 1'b0;

    // Reset state
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_empty", 32'(bus.chn_sdu_empty), 32'd1);
    chk("rst_dval",  32'(bus.chn_sdu_dval),  32'd0);
    chk("rst_data",  32'(bus.chn_sdu_data),  32'd0);
    chk("rst_pkt",   32'(bus.pkt_cnt),       32'd0);
    chk("rst_drop",  32'(bus.drop_cnt),      32'd0);

    // 1: single 4-word packet
    step(1'b1, 18'h2A001, 1'b0);
    step(1'b1, 18'h0A002, 1'b0);
    step(1'b1, 18'h0A003, 1'b0);
    chk("t1_empty_pre", 32'(bus.chn_sdu_empty), 32'd1);
    step(1'b1, 18'h1A004, 1'b0);
    chk("t1_empty_post", 32'(bus.chn_sdu_empty), 32'd0);
    chk("t1_pkt", 32'(bus.pkt_cnt), 32'd1);
    pop_chk("t1_p0", 18'h2A001);
    pop_chk("t1_p1", 18'h0A002);
    pop_chk("t1_p2", 18'h0A003);
    chk("t1_pkt_mid", 32'(bus.pkt_cnt), 32'd1);
    pop_chk("t1_p3", 18'h1A004);
    chk("t1_empty_end", 32'(bus.chn_sdu_empty), 32'd1);
    chk("t1_pkt_end", 32'(bus.pkt_cnt), 32'd0);
    step(1'b0, 18'h0, 1'b0);
    chk("t1_dval_idle", 32'(bus.chn_sdu_dval), 32'd0);
    chk("t1_data_idle", 32'(bus.chn_sdu_data), 32'd0);

    // 2: sop inside a packet drops the partial one
    step(1'b1, 18'h20001, 1'b0);
    step(1'b1, 18'h00002, 1'b0);
    step(1'b1, 18'h20010, 1'b0);
    step(1'b1, 18'h10011, 1'b0);
    chk("t2_drop", 32'(bus.drop_cnt), 32'd1);
    chk("t2_pkt",  32'(bus.pkt_cnt),  32'd1);
    pop_chk("t2_p0", 18'h20010);
    pop_chk("t2_p1", 18'h10011);
    chk("t2_empty", 32'(bus.chn_sdu_empty), 32'd1);

    // 3: 20-word packet overflows a 15-word store
    for (int i = 0; i < 20; i++) begin
      d = 18'(16'h3000 + i);
      if (i == 0)  d[17] = 1'b1;
      if (i == 19) d[16] = 1'b1;
      step(1'b1, d, 1'b0);
      if (i == 19) begin
        chk("t3_empty_long", 32'(bus.chn_sdu_empty), 32'd1);
      end
    end
    chk("t3_drop", 32'(bus.drop_cnt), 32'd2);
    chk("t3_pkt",  32'(bus.pkt_cnt),  32'd0);
    step(1'b1, 18'h23001, 1'b0);
    step(1'b1, 18'h03002, 1'b0);
    step(1'b1, 18'h13003, 1'b0);
    chk("t3_pkt_short", 32'(bus.pkt_cnt), 32'd1);
    pop_chk("t3_p0", 18'h23001);
    pop_chk("t3_p1", 18'h03002);
    pop_chk("t3_p2", 18'h13003);

    // 5: rden while empty, sop-less words in IDLE
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 18'h0, 1'b1);
      chk("t5_dval", 32'(bus.chn_sdu_dval), 32'd0);
      chk("t5_data", 32'(bus.chn_sdu_data), 32'd0);
    end
    step(1'b1, 18'h00005, 1'b1);
    step(1'b1, 18'h10006, 1'b1);
    chk("t5_drop",  32'(bus.drop_cnt),      32'd2);
    chk("t5_pkt",   32'(bus.pkt_cnt),       32'd0);
    chk("t5_empty", 32'(bus.chn_sdu_empty), 32'd1);
    chk("t5_dval2", 32'(bus.chn_sdu_dval),  32'd0);

    // 4: wrap past 15 with concurrent push/pop, commit and eop-pop together
    step(1'b1, 18'h20A00, 1'b0);
    step(1'b1, 18'h00A01, 1'b0);
    step(1'b1, 18'h00A02, 1'b0);
    step(1'b1, 18'h10A03, 1'b0);
    step(1'b1, 18'h20B00, 1'b0);
    step(1'b1, 18'h00B01, 1'b0);
    step(1'b1, 18'h00B02, 1'b0);
    step(1'b1, 18'h10B03, 1'b0);
    chk("t4_pkt_ab", 32'(bus.pkt_cnt), 32'd2);
    step(1'b1, 18'h20C00, 1'b1);
    chk("t4_c0_data", 32'(bus.chn_sdu_data), 32'h20A00);
    step(1'b1, 18'h00C01, 1'b1);
    chk("t4_c1_data", 32'(bus.chn_sdu_data), 32'h00A01);
    step(1'b1, 18'h00C02, 1'b1);
    chk("t4_c2_data", 32'(bus.chn_sdu_data), 32'h00A02);
    chk("t4_c2_pkt",  32'(bus.pkt_cnt),      32'd2);
    step(1'b1, 18'h10C03, 1'b1);
    chk("t4_c3_data", 32'(bus.chn_sdu_data), 32'h10A03);
    chk("t4_c3_pkt",  32'(bus.pkt_cnt),      32'd2);
    pop_chk("t4_b0", 18'h20B00);
    pop_chk("t4_b1", 18'h00B01);
    pop_chk("t4_b2", 18'h00B02);
    pop_chk("t4_b3", 18'h10B03);
    chk("t4_pkt_b", 32'(bus.pkt_cnt), 32'd1);
    pop_chk("t4_d0", 18'h20C00);
    pop_chk("t4_d1", 18'h00C01);
    pop_chk("t4_d2", 18'h00C02);
    pop_chk("t4_d3", 18'h10C03);
    chk("t4_pkt_end",   32'(bus.pkt_cnt),       32'd0);
    chk("t4_empty_end", 32'(bus.chn_sdu_empty), 32'd1);

    // 6: reset mid-packet with two packets stored
    step(1'b1, 18'h2E000, 1'b0);
    step(1'b1, 18'h1E001, 1'b0);
    step(1'b1, 18'h2E100, 1'b0);
    step(1'b1, 18'h1E101, 1'b0);
    step(1'b1, 18'h2E200, 1'b0);
    chk("t6_pkt_pre",  32'(bus.pkt_cnt),  32'd2);
    chk("t6_drop_pre", 32'(bus.drop_cnt), 32'd2);
    rst = 1'b0;
    step(1'b1, 18'h00E02, 1'b1);
    rst = 1'b1;
    chk("t6_empty", 32'(bus.chn_sdu_empty), 32'd1);
    chk("t6_pkt",   32'(bus.pkt_cnt),       32'd0);
    chk("t6_drop",  32'(bus.drop_cnt),      32'd0);
    chk("t6_dval",  32'(bus.chn_sdu_dval),  32'd0);
    step(1'b1, 18'h3F0F0, 1'b0);
    chk("t6_pkt_new", 32'(bus.pkt_cnt), 32'd1);
    pop_chk("t6_p0", 18'h3F0F0);
    chk("t6_empty_end", 32'(bus.chn_sdu_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
